// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush/redirect controller with saturating perf counters
module pipeline_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_hazard,
    input  logic                  mispredict,
    input  logic [DATA_WIDTH-1:0] target_ex,
    input  logic                  dmem_busy,
    input  logic                  fetch_ready,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_write_en,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e                  state_q;
    logic                    redirect_valid_q;
    logic [DATA_WIDTH-1:0]   redirect_pc_q;
    logic [CNT_WIDTH-1:0]    stall_cycles_q;
    logic [CNT_WIDTH-1:0]    stall_cycles_d;
    logic [CNT_WIDTH-1:0]    mispredict_cnt_q;
    logic [CNT_WIDTH-1:0]    mispredict_cnt_d;

    // A mispredict is only accepted in RUN when memory is not freezing the pipe
    logic take_mispredict;
    logic redirect_done;

    assign take_mispredict = (state_q == ST_RUN) && !dmem_busy && mispredict;
    assign redirect_done   = (state_q == ST_REDIRECT) && redirect_valid_q && fetch_ready;

    // Stage enables and flushes by state, with freeze > mispredict > load-use > run priority
    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_write_en = 1'b1;
        if (state_q == ST_REDIRECT) begin
            // Keep squashing the front end until fetch takes the new PC
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            ex_mem_write_en = !dmem_busy;
        end else if (dmem_busy) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
        end else if (mispredict) begin
            // Wrong-path instructions in IF/ID and ID become bubbles
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
        end else if (mem_hazard) begin
            // Hold IF/ID and PC, insert one bubble into ID/EX
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_flush     = 1'b1;
        end
    end

    // FSM with registered redirect handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (take_mispredict) begin
                        redirect_pc_q    <= target_ex;
                        redirect_valid_q <= 1'b1;
                        state_q          <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_done) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= ST_RUN;
                    end
                end
                default: begin
                    state_q          <= ST_RUN;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating next-state for the perf counters
    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (!pc_write_en && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
        if (take_mispredict && (mispredict_cnt_q != CNT_MAX)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_ONE;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q   <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall_cycles   = stall_cycles_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_hazard = 1'b0;
    logic          mispredict = 1'b0;
    logic [DW-1:0] target_ex = '0;
    logic          dmem_busy = 1'b0;
    logic          fetch_ready = 1'b0;
    logic          pc_write_en;
    logic          if_id_write_en;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          ex_mem_write_en;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] mispredict_cnt;

    pipeline_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_hazard      (mem_hazard),
        .mispredict      (mispredict),
        .target_ex       (target_ex),
        .dmem_busy       (dmem_busy),
        .fetch_ready     (fetch_ready),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_write_en (ex_mem_write_en),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall_cycles    (stall_cycles),
        .mispredict_cnt  (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_write_en}
    typedef struct {
        string         name;
        logic [4:0]    ctl;
        logic          rv;
        logic [DW-1:0] rpc;
        logic [CW-1:0] stall;
        logic [CW-1:0] mcnt;
    } exp_t;

    localparam logic [4:0] C_RUN    = 5'b11001;
    localparam logic [4:0] C_LOAD   = 5'b00011;
    localparam logic [4:0] C_MISP   = 5'b01111;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_RDB    = 5'b01110;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Monitor: compare every cycle that has a pending expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, ".ctl"}, DW'({pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_write_en}), DW'(e.ctl));
            chk({e.name, ".rv"}, DW'(redirect_valid), DW'(e.rv));
            chk({e.name, ".rpc"}, redirect_pc, e.rpc);
            chk({e.name, ".stall"}, DW'(stall_cycles), DW'(e.stall));
            chk({e.name, ".mcnt"}, DW'(mispredict_cnt), DW'(e.mcnt));
        end
    end

    task automatic push(input string name, input logic [4:0] ctl, input logic rv,
                        input logic [DW-1:0] rpc, input int stall, input int mcnt);
        exp_t e;
        e.name  = name;
        e.ctl   = ctl;
        e.rv    = rv;
        e.rpc   = rpc;
        e.stall = CW'(stall);
        e.mcnt  = CW'(mcnt);
        sb_q.push_back(e);
    endtask

    task automatic step(input string name, input logic mh, input logic mp, input logic busy,
                        input logic rdy, input logic [DW-1:0] tgt, input logic [4:0] ctl,
                        input logic rv, input logic [DW-1:0] rpc, input int stall, input int mcnt);
        @(posedge clk);
        #1;
        mem_hazard  = mh;
        mispredict  = mp;
        dmem_busy   = busy;
        fetch_ready = rdy;
        target_ex   = tgt;
        push(name, ctl, rv, rpc, stall, mcnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n     = 1'b0;
        mem_hazard  = 1'b0;
        mispredict  = 1'b0;
        dmem_busy   = 1'b0;
        fetch_ready = 1'b0;
        target_ex   = '0;
        @(posedge clk);
        #1;
        push("reset", C_RUN, 1'b0, '0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        // 1: load-use hazard
        do_reset();
        step("lu_hz",   1, 0, 0, 0, '0, C_LOAD, 0, '0, 0, 0);
        step("lu_next", 0, 0, 0, 0, '0, C_RUN,  0, '0, 1, 0);

        // 2: mispredict with fetch ready
        do_reset();
        step("mp_n",   0, 1, 0, 1, 64'h1000, C_MISP, 0, '0,       0, 0);
        step("mp_n1",  0, 0, 0, 1, '0,       C_MISP, 1, 64'h1000, 1, 1);
        step("mp_n2",  0, 0, 0, 1, '0,       C_RUN,  0, 64'h1000, 2, 1);

        // 3: fetch back-pressure, later mispredicts ignored while redirecting
        do_reset();
        step("bp_n",  0, 1, 0, 0, 64'h2468, C_MISP, 0, '0,       0, 0);
        step("bp_w1", 0, 0, 0, 0, '0,       C_MISP, 1, 64'h2468, 1, 1);
        step("bp_w2", 1, 1, 0, 0, 64'hdead, C_MISP, 1, 64'h2468, 2, 1);
        step("bp_w3", 0, 0, 0, 0, '0,       C_MISP, 1, 64'h2468, 3, 1);
        step("bp_ok", 0, 0, 0, 1, '0,       C_MISP, 1, 64'h2468, 4, 1);
        step("bp_end",0, 0, 0, 0, '0,       C_RUN,  0, 64'h2468, 5, 1);

        // 4: freeze beats mispredict; handshake completes while memory busy
        do_reset();
        step("fz_1",   0, 1, 1, 0, 64'h3000, C_FREEZE, 0, '0,       0, 0);
        step("fz_2",   0, 1, 1, 0, 64'h3000, C_FREEZE, 0, '0,       1, 0);
        step("fz_mp",  0, 1, 0, 0, 64'h3000, C_MISP,   0, '0,       2, 0);
        step("fz_rdb", 0, 0, 1, 1, '0,       C_RDB,    1, 64'h3000, 3, 1);
        step("fz_end", 0, 0, 0, 0, '0,       C_RUN,    0, 64'h3000, 4, 1);

        // 5: simultaneous hazard and mispredict
        do_reset();
        step("both",     1, 1, 0, 1, 64'h4000, C_MISP, 0, '0,       0, 0);
        step("both_rd",  0, 0, 0, 1, '0,       C_MISP, 1, 64'h4000, 1, 1);
        step("both_end", 0, 0, 0, 0, '0,       C_RUN,  0, 64'h4000, 2, 1);

        // 6a: asynchronous reset in the middle of a redirect
        do_reset();
        step("ar_mp", 0, 1, 0, 0, 64'h5000, C_MISP, 0, '0,       0, 0);
        step("ar_rd", 0, 0, 0, 0, '0,       C_MISP, 1, 64'h5000, 1, 1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar.rv",    DW'(redirect_valid), '0);
        chk("ar.rpc",   redirect_pc, '0);
        chk("ar.stall", DW'(stall_cycles), '0);
        chk("ar.mcnt",  DW'(mispredict_cnt), '0);
        chk("ar.pcwe",  DW'(pc_write_en), DW'(1));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 6b: stall counter saturation
        for (int k = 0; k < 20; k++)
            step("sat_st", 1, 0, 0, 0, '0, C_LOAD, 0, '0, sat(k), 0);
        step("sat_st_end", 0, 0, 0, 0, '0, C_RUN, 0, '0, 15, 0);

        // 6c: mispredict counter saturation
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step("sat_mp", 0, 1, 0, 0, 64'(256 * (k + 1)), C_MISP, 0,
                 (k == 0) ? 64'h0 : 64'(256 * k), sat(2 * k), sat(k));
            step("sat_rd", 0, 0, 0, 1, '0, C_MISP, 1, 64'(256 * (k + 1)), sat(2 * k + 1), sat(k + 1));
        end
        step("sat_mp_end", 0, 0, 0, 0, '0, C_RUN, 0, 64'(256 * 17), 15, 15);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("sb_drain", DW'(sb_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
